// File: rtl/tank_bullet_ctrl.sv
// tank_bullet_ctrl: fires, moves, bounces and retires up to NUM_SLOTS tank bullets once per frame.
// Define BULLET_BOUNCE_LIMIT_EN to also retire a bullet once it exceeds MAX_BOUNCES wall contacts.
module tank_bullet_ctrl #(
  parameter int NUM_SLOTS = 4,
  parameter logic [7:0] FIRE_KEY = 8'h10,
  parameter int BULLET_SPEED = 8,
  parameter logic [7:0] LIFETIME = 8'd255,
  parameter logic [7:0] COOLDOWN = 8'd8,
  parameter int X_MIN = 0,
  parameter int X_MAX = 639,
  parameter int Y_MIN = 0,
  parameter int Y_MAX = 479
`ifdef BULLET_BOUNCE_LIMIT_EN
  , parameter int MAX_BOUNCES = 3
`endif
) (
  input  logic                     frame_clk,
  input  logic                     Reset,
  input  logic [31:0]              keycode,
  input  logic [9:0]               TankX,
  input  logic [9:0]               TankY,
  input  logic [7:0]               sin,
  input  logic [7:0]               cos,
  input  logic [NUM_SLOTS-1:0]     Hit,
  output logic [10*NUM_SLOTS-1:0]  BulletX,
  output logic [10*NUM_SLOTS-1:0]  BulletY,
  output logic [NUM_SLOTS-1:0]     BulletActive,
  output logic [9:0]               BulletS
);
  logic key_now, key_prev, fire;
  logic [7:0] cooldown;
  logic [NUM_SLOTS-1:0] spawn;
  logic [9:0] mag_x, mag_y, vx_new, vy_new;
  assign BulletS = 10'd4;
  assign key_now = keycode[7:0] == FIRE_KEY || keycode[15:8] == FIRE_KEY ||
                   keycode[23:16] == FIRE_KEY || keycode[31:24] == FIRE_KEY;
  assign fire = key_now && !key_prev && cooldown == 8'd0;
  // lowest clear bit of BulletActive, one-hot
  assign spawn = {NUM_SLOTS{fire}} & ~BulletActive & (BulletActive + NUM_SLOTS'(1));
  assign mag_x = 10'((BULLET_SPEED * int'(cos[6:0])) >> 7);
  assign mag_y = 10'((BULLET_SPEED * int'(sin[6:0])) >> 7);
  assign vx_new = cos[7] ? -mag_x : mag_x;
  // screen Y grows downward, so a positive sine moves up
  assign vy_new = sin[7] ? mag_y : -mag_y;
  always_ff @(posedge frame_clk or posedge Reset)
    if (Reset) begin
      key_prev <= 1'b0;
      cooldown <= '0;
    end else begin
      key_prev <= key_now;
      cooldown <= |spawn ? COOLDOWN : cooldown - 8'(cooldown != 8'd0);
    end
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    logic [9:0] x, y, vx, vy;
    logic [7:0] life;
    logic act, hx, hy, over;
    logic signed [10:0] nx, ny;
    assign nx = $signed({1'b0, x}) + $signed({vx[9], vx});
    assign ny = $signed({1'b0, y}) + $signed({vy[9], vy});
    assign hx = nx < 11'(X_MIN) || nx > 11'(X_MAX);
    assign hy = ny < 11'(Y_MIN) || ny > 11'(Y_MAX);
`ifdef BULLET_BOUNCE_LIMIT_EN
    logic [7:0] bounces, bounces_next;
    assign bounces_next = bounces + 8'(hx) + 8'(hy);
    assign over = bounces_next > 8'(MAX_BOUNCES);
    always_ff @(posedge frame_clk or posedge Reset)
      if (Reset) bounces <= '0;
      else if (spawn[i]) bounces <= '0;
      else if (act && !Hit[i]) bounces <= bounces_next;
`else
    assign over = 1'b0;
`endif
    always_ff @(posedge frame_clk or posedge Reset)
      if (Reset) begin
        x <= '0;
        y <= '0;
        vx <= '0;
        vy <= '0;
        life <= '0;
        act <= 1'b0;
      end else if (spawn[i]) begin
        x <= TankX;
        y <= TankY;
        vx <= vx_new;
        vy <= vy_new;
        life <= LIFETIME;
        act <= 1'b1;
      end else if (act) begin
        if (Hit[i] || over) act <= 1'b0;
        else begin
          x <= hx ? x : nx[9:0];
          vx <= hx ? -vx : vx;
          y <= hy ? y : ny[9:0];
          vy <= hy ? -vy : vy;
          life <= life - 8'd1;
          act <= life != 8'd1;
        end
      end
    assign BulletX[10*i +: 10] = x;
    assign BulletY[10*i +: 10] = y;
    assign BulletActive[i] = act;
  end
endmodule

// File: tb/tb_tank_bullet_ctrl.sv
// tb_tank_bullet_ctrl: scoreboard bench for tank_bullet_ctrl; a frame-level bullet model
// predicts every frame's outputs, and a monitor compares them after each clock edge.
module tb_tank_bullet_ctrl;
  localparam int LT = 100, CD = 8, SPD = 8;
  localparam int XMAX = 639, YMAX = 479, MAXB = 3;
  localparam logic [7:0] FK = 8'h10;
  logic frame_clk = 1'b0, Reset = 1'b1;
  logic [31:0] keycode = '0;
  logic [9:0] TankX = '0, TankY = '0;
  logic [7:0] sin = '0, cos = '0;
  logic [3:0] Hit = '0;
  logic [39:0] BulletX, BulletY;
  logic [3:0] BulletActive;
  logic [9:0] BulletS;
  tank_bullet_ctrl #(.LIFETIME(8'(LT))) dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .TankX(TankX), .TankY(TankY),
    .sin(sin), .cos(cos), .Hit(Hit), .BulletX(BulletX), .BulletY(BulletY),
    .BulletActive(BulletActive), .BulletS(BulletS));
  always #5 frame_clk = ~frame_clk;
  typedef struct { logic [39:0] x, y; logic [3:0] a; } snap_t;
  snap_t q[$];
  int n_pass = 0, n_total = 0;
  int mx[4], my[4], mvx[4], mvy[4], mlife[4], mb[4], mcd;
  bit mact[4], mkp;
  task automatic check(string name, logic [39:0] got, logic [39:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
  endtask
  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      mx[i] = 0; my[i] = 0; mvx[i] = 0; mvy[i] = 0; mlife[i] = 0; mb[i] = 0; mact[i] = 0;
    end
    mcd = 0; mkp = 0;
  endfunction
  function automatic void push_snap();
    snap_t e;
    for (int i = 0; i < 4; i++) begin
      e.x[10*i +: 10] = 10'(mx[i]);
      e.y[10*i +: 10] = 10'(my[i]);
      e.a[i] = mact[i];
    end
    q.push_back(e);
  endfunction
  // one frame of the game rules, evaluated on the state seen before the edge
  function automatic void model_step(logic [31:0] k, int tx, int ty, logic [7:0] s, logic [7:0] c, logic [3:0] h);
    bit kn, fire;
    int fs, nx, ny, hx, hy, mc, ms;
    kn = 0; fs = -1;
    for (int b = 0; b < 4; b++) if (k[8*b +: 8] == FK) kn = 1;
    for (int i = 3; i >= 0; i--) if (!mact[i]) fs = i;
    fire = kn && !mkp && mcd == 0;
    mc = (SPD * int'(c[6:0])) / 128;
    ms = (SPD * int'(s[6:0])) / 128;
    for (int i = 0; i < 4; i++) begin
      if (fire && i == fs) begin
        mx[i] = tx; my[i] = ty; mvx[i] = c[7] ? -mc : mc; mvy[i] = s[7] ? ms : -ms;
        mlife[i] = LT; mb[i] = 0; mact[i] = 1;
      end else if (mact[i]) begin
        if (h[i]) mact[i] = 0;
        else begin
          nx = mx[i] + mvx[i]; ny = my[i] + mvy[i];
          hx = (nx < 0 || nx > XMAX) ? 1 : 0;
          hy = (ny < 0 || ny > YMAX) ? 1 : 0;
`ifdef BULLET_BOUNCE_LIMIT_EN
          if (mb[i] + hx + hy > MAXB) begin mact[i] = 0; continue; end
          mb[i] += hx + hy;
`endif
          if (hx != 0) mvx[i] = -mvx[i]; else mx[i] = nx;
          if (hy != 0) mvy[i] = -mvy[i]; else my[i] = ny;
          if (mlife[i] == 1) mact[i] = 0;
          mlife[i]--;
        end
      end
    end
    mcd = (fire && fs >= 0) ? CD : (mcd > 0 ? mcd - 1 : 0);
    mkp = kn;
  endfunction
  task automatic step(logic [31:0] k, int tx, int ty, logic [7:0] s, logic [7:0] c, logic [3:0] h);
    @(negedge frame_clk);
    Reset = 1'b0; keycode = k; TankX = 10'(tx); TankY = 10'(ty); sin = s; cos = c; Hit = h;
    model_step(k, tx, ty, s, c, h);
    push_snap();
  endtask
  task automatic async_reset();
    @(negedge frame_clk);
    #2 Reset = 1'b1;
    #1;
    check("async_rst_x", BulletX, '0);
    check("async_rst_y", BulletY, '0);
    check("async_rst_active", {36'd0, BulletActive}, '0);
    model_reset();
    push_snap();
  endtask
  initial begin : monitor
    snap_t e;
    forever begin
      @(posedge frame_clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("bullet_x", BulletX, e.x);
        check("bullet_y", BulletY, e.y);
        check("bullet_active", {36'd0, BulletActive}, {36'd0, e.a});
        check("bullet_size", {30'd0, BulletS}, 40'd4);
      end
    end
  end
  initial begin : driver
    logic [31:0] k;
    model_reset();
    #1;
    check("reset_x", BulletX, '0);
    check("reset_y", BulletY, '0);
    check("reset_active", {36'd0, BulletActive}, '0);
    step({24'd0, FK}, 300, 250, 8'h00, 8'h7F, 4'd0);
    repeat (3) step(0, 300, 250, 8'h00, 8'h7F, 4'd0);
    repeat (20) step(32'h0000_1000, 100, 100, 8'h40, 8'hC0, 4'd0);
    repeat (8) step(0, 100, 100, 8'h40, 8'hC0, 4'd0);
    step(32'h1000_0000, 200, 300, 8'h85, 8'h22, 4'd0);
    step(0, 200, 300, 8'h85, 8'h22, 4'd0);
    step(32'h0010_0000, 50, 60, 8'h11, 8'h7F, 4'd0);
    repeat (10) step(0, 50, 60, 8'h11, 8'h7F, 4'd0);
    async_reset();
    step({24'd0, FK}, 636, 2, 8'h7F, 8'h7F, 4'd0);
    repeat (4) step(0, 636, 2, 8'h7F, 8'h7F, 4'd0);
    async_reset();
    for (int f = 0; f < 5; f++) begin
      step({24'd0, FK}, 320, 240, 8'h00, 8'h00, 4'd0);
      repeat (9) step(0, 320, 240, 8'h00, 8'h00, 4'd0);
    end
    step(0, 320, 240, 8'h00, 8'h00, 4'b0100);
    step({FK, 24'd0}, 10, 20, 8'h00, 8'h00, 4'd0);
    repeat (3) step(0, 10, 20, 8'h00, 8'h00, 4'd0);
    async_reset();
    step({24'd0, FK}, 320, 240, 8'h00, 8'h00, 4'd0);
    repeat (LT + 3) step(0, 320, 240, 8'h00, 8'h00, 4'd0);
    async_reset();
    step({24'd0, FK}, 636, 2, 8'h7F, 8'h7F, 4'd0);
    repeat (LT + 2) step(0, 636, 2, 8'h7F, 8'h7F, 4'd0);
    repeat (1500) begin
      if ($urandom_range(0, 299) == 0) async_reset();
      else begin
        k = $urandom;
        if ($urandom_range(0, 2) == 0) k[8*$urandom_range(0, 3) +: 8] = FK;
        step(k, $urandom_range(0, 639), $urandom_range(0, 479), 8'($urandom), 8'($urandom),
             $urandom_range(0, 7) == 0 ? 4'($urandom) : 4'd0);
      end
    end
    repeat (3) @(negedge frame_clk);
    check("queue_drained", 40'(q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
